// File: rtl/board_pkg.sv
// Board-wide constants shared by the physical top and the game logic.
package board_pkg;

    localparam int unsigned CLK_HZ          = 27_000_000;
    localparam int unsigned BUTTON_COUNT    = 5;
    localparam int unsigned DEBOUNCE_MS     = 10;
    localparam int unsigned DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, stability counter, accepted level
// and one-cycle press/release pulses.
module debounce_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
    input  logic clk_27M,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pressed,
    output logic released
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync0;
    logic             sync1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_27M) begin
        if (rst) begin
            sync0    <= 1'b0;
            sync1    <= 1'b0;
            level    <= 1'b0;
            cnt      <= '0;
            pressed  <= 1'b0;
            released <= 1'b0;
        end else begin
            sync0    <= raw;
            sync1    <= sync0;
            pressed  <= 1'b0;
            released <= 1'b0;
            // Any sample agreeing with the accepted level discards the run so far.
            if (sync1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level    <= sync1;
                cnt      <= '0;
                pressed  <= sync1;
                released <= ~sync1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Synchronises and debounces the active-high button vector; every channel is
// an independent debounce_channel instance.
module button_conditioner
    import board_pkg::*;
#(
    parameter int unsigned WIDTH           = BUTTON_COUNT,
    parameter int unsigned DEBOUNCE_CYCLES = board_pkg::DEBOUNCE_CYCLES
) (
    input  logic             clk_27M,
    input  logic             rst,
    input  logic [WIDTH-1:0] buttons_raw,
    output logic [WIDTH-1:0] buttons_level,
    output logic [WIDTH-1:0] buttons_pressed,
    output logic [WIDTH-1:0] buttons_released
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk_27M (clk_27M),
            .rst     (rst),
            .raw     (buttons_raw[i]),
            .level   (buttons_level[i]),
            .pressed (buttons_pressed[i]),
            .released(buttons_released[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a window-based reference model
// checked every cycle, plus literal expectations at key edges.
module tb_button_conditioner;

    localparam int unsigned W = 5;
    localparam int unsigned N = 4;

    logic         clk_27M = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] buttons_raw = '0;
    logic [W-1:0] buttons_level;
    logic [W-1:0] buttons_pressed;
    logic [W-1:0] buttons_released;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    button_conditioner #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk_27M         (clk_27M),
        .rst             (rst),
        .buttons_raw     (buttons_raw),
        .buttons_level   (buttons_level),
        .buttons_pressed (buttons_pressed),
        .buttons_released(buttons_released)
    );

    always #5 clk_27M = ~clk_27M;

    // Reference: raw passes through a two-sample delay; a channel accepts when
    // the last N delayed samples all disagree with its accepted level.
    logic [W-1:0] m_d0 = '0, m_d1 = '0;
    logic [W-1:0] m_level = '0, m_pressed = '0, m_released = '0;
    bit           hist [W][$];

    always @(posedge clk_27M) begin
        if (rst) begin
            m_d0 = '0; m_d1 = '0;
            m_level = '0; m_pressed = '0; m_released = '0;
            for (int c = 0; c < W; c++) hist[c].delete();
        end else begin
            for (int c = 0; c < W; c++) begin
                bit all_new;
                hist[c].push_back(m_d1[c]);
                if (hist[c].size() > N) void'(hist[c].pop_front());
                m_pressed[c]  = 1'b0;
                m_released[c] = 1'b0;
                all_new = (hist[c].size() == N);
                foreach (hist[c][k]) if (hist[c][k] == m_level[c]) all_new = 1'b0;
                if (all_new) begin
                    m_level[c]    = ~m_level[c];
                    m_pressed[c]  = m_level[c];
                    m_released[c] = ~m_level[c];
                end
            end
            m_d1 = m_d0;
            m_d0 = buttons_raw;
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_27M) begin
        if (checking) begin
            check("model_level", buttons_level, m_level);
            check("model_pressed", buttons_pressed, m_pressed);
            check("model_released", buttons_released, m_released);
        end
    end

    // Literal pin: both the DUT and the model must agree with a hand value.
    task automatic lit(input string name, input logic [W-1:0] dut_v,
                       input logic [W-1:0] mdl_v, input logic [W-1:0] exp);
        check({name, "_dut"}, dut_v, exp);
        check({name, "_model"}, mdl_v, exp);
    endtask

    task automatic edge_();
        @(posedge clk_27M);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) edge_();
    endtask

    logic [7:0] bounce_pat;
    logic       glitch_seen;

    initial begin
        // Reset with all buttons held
        rst = 1'b1;
        buttons_raw = '1;
        for (int i = 0; i < 3; i++) begin
            edge_();
            checking = 1'b1;
            check("rst_level", buttons_level, '0);
            check("rst_pressed", buttons_pressed, '0);
            check("rst_released", buttons_released, '0);
        end
        rst = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            edge_();
            if (e == 4) lit("held_pre_level", buttons_level, m_level, '0);
            if (e == 5) begin
                lit("held_level", buttons_level, m_level, '1);
                lit("held_pressed", buttons_pressed, m_pressed, '1);
            end
            if (e == 6) lit("held_pressed_end", buttons_pressed, m_pressed, '0);
        end
        buttons_raw = '0;
        for (int e = 0; e <= 6; e++) begin
            edge_();
            if (e == 5) begin
                lit("all_released", buttons_released, m_released, '1);
                lit("all_rel_level", buttons_level, m_level, '0);
            end
            if (e == 6) lit("all_rel_end", buttons_released, m_released, '0);
        end
        idle(3);

        // Clean press and release on channel 2
        buttons_raw = 5'b00100;
        for (int e = 0; e <= 27; e++) begin
            if (e == 20) buttons_raw = '0;
            edge_();
            if (e == 4) lit("c2_pre_pressed", buttons_pressed, m_pressed, '0);
            if (e == 5) begin
                lit("c2_level", buttons_level, m_level, 5'b00100);
                lit("c2_pressed", buttons_pressed, m_pressed, 5'b00100);
            end
            if (e == 6) lit("c2_pressed_end", buttons_pressed, m_pressed, '0);
            if (e == 24) lit("c2_pre_release", buttons_level, m_level, 5'b00100);
            if (e == 25) begin
                lit("c2_released", buttons_released, m_released, 5'b00100);
                lit("c2_rel_level", buttons_level, m_level, '0);
            end
            if (e == 26) lit("c2_released_end", buttons_released, m_released, '0);
        end
        idle(3);

        // Bounce on channel 1: final rise before edge 4, acceptance at edge 9
        bounce_pat = 8'b1111_0111;
        for (int e = 0; e <= 11; e++) begin
            buttons_raw[1] = (e < 8) ? bounce_pat[e] : 1'b1;
            edge_();
            if (e == 5) lit("bounce_no_early", buttons_pressed, m_pressed, '0);
            if (e == 8) lit("bounce_pre_level", buttons_level, m_level, '0);
            if (e == 9) lit("bounce_pressed", buttons_pressed, m_pressed, 5'b00010);
            if (e == 10) lit("bounce_level", buttons_level, m_level, 5'b00010);
        end
        buttons_raw = '0;
        idle(10);

        // Sub-threshold glitch on channel 3
        glitch_seen = 1'b0;
        for (int e = 0; e <= 11; e++) begin
            buttons_raw[3] = (e < 3);
            edge_();
            if ((buttons_pressed | buttons_released | buttons_level) != '0) glitch_seen = 1'b1;
        end
        check("glitch_no_activity", {4'b0, glitch_seen}, '0);
        lit("glitch_level", buttons_level, m_level, '0);

        // Simultaneous channels 0 and 4
        buttons_raw = 5'b10001;
        for (int e = 0; e <= 6; e++) begin
            edge_();
            if (e == 5) begin
                lit("simul_pressed", buttons_pressed, m_pressed, 5'b10001);
                lit("simul_level", buttons_level, m_level, 5'b10001);
            end
            if (e == 6) lit("simul_pressed_end", buttons_pressed, m_pressed, '0);
        end
        buttons_raw = '0;
        idle(10);

        // Reset in the middle of a count on channel 2
        buttons_raw = 5'b00100;
        idle(4);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            edge_();
            check("midrst_level", buttons_level, '0);
            check("midrst_pressed", buttons_pressed, '0);
        end
        rst = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            edge_();
            if (e == 4) lit("midrst_pre_level", buttons_level, m_level, '0);
            if (e == 5) begin
                lit("midrst_pressed_post", buttons_pressed, m_pressed, 5'b00100);
                lit("midrst_level_post", buttons_level, m_level, 5'b00100);
            end
            if (e == 6) lit("midrst_pressed_end", buttons_pressed, m_pressed, '0);
        end
        buttons_raw = '0;
        idle(10);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
